// File: rtl/neurosync_serial_pkg.sv
// Shared frame format and receiver state codes for the neurosync serial link.
package neurosync_serial_pkg;

  // Defaults shared with the transmitter so both ends agree on the frame.
  localparam int BAUD_DIV_DEF  = 434;
  localparam int DATA_BITS_DEF = 7;

  // Receiver FSM state codes; also shown on the hex display.
  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    PARTIDA  = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    FIM      = 4'd5,
    ESPERA   = 4'd6
  } estado_e;

endpackage

// File: rtl/neurosync_rx_serial_fd.sv
// Receiver datapath: input synchronizer, bit-time counter, bit index,
// shift register, parity accumulator and the registered result word.
module neurosync_rx_serial_fd #(
  parameter int BAUD_DIV    = 434,
  parameter int DATA_BITS   = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  input  logic                 zera_cnt,
  input  logic                 zera_dados,
  input  logic                 desloca,
  input  logic                 amostra_par,
  input  logic                 carrega,
  output logic                 rx_s,
  output logic                 meio,
  output logic                 fim,
  output logic                 ultimo,
  output logic [DATA_BITS-1:0] dados,
  output logic                 erro_paridade,
  output logic                 erro_parada
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] MEIO_C = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FIM_C  = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] ULT_C  = IW'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   sr_q, sr_d;
  logic                   par_q, par_d;
  logic [DATA_BITS-1:0]   dados_q, dados_d;
  logic                   ep_q, ep_d;
  logic                   es_q, es_d;

  assign rx_s          = sync_q[SYNC_STAGES-1];
  assign meio          = (cnt_q == MEIO_C);
  assign fim           = (cnt_q == FIM_C);
  assign ultimo        = (idx_q == ULT_C);
  assign dados         = dados_q;
  assign erro_paridade = ep_q;
  assign erro_parada   = es_q;

  // Next-state for all datapath registers.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], dado_serial};

    cnt_d = (zera_cnt || fim) ? '0 : cnt_q + 1'b1;

    idx_d = idx_q;
    sr_d  = sr_q;
    par_d = par_q;
    if (zera_dados) begin
      idx_d = '0;
      sr_d  = '0;
      par_d = 1'b0;
    end else begin
      if (desloca) begin
        idx_d = idx_q + 1'b1;
        // LSB arrives first, so new bits enter at the top and shift down.
        sr_d                = sr_q >> 1;
        sr_d[DATA_BITS-1]   = rx_s;
      end
      if (desloca || amostra_par) par_d = par_q ^ rx_s;
    end

    // Result is loaded as the stop bit is sampled so it is valid during FIM.
    dados_d = dados_q;
    ep_d    = ep_q;
    es_d    = es_q;
    if (carrega) begin
      dados_d = sr_q;
      ep_d    = ~par_q;
      es_d    = ~rx_s;
    end
  end

  // Datapath registers; synchronizer presets to idle-high to avoid a false start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      dados_q <= '0;
      ep_q    <= 1'b0;
      es_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      dados_q <= dados_d;
      ep_q    <= ep_d;
      es_q    <= es_d;
    end
  end

endmodule

// File: rtl/neurosync_rx_serial.sv
// 7O1 UART receiver: control FSM plus the datapath instance.
module neurosync_rx_serial
  import neurosync_serial_pkg::*;
#(
  parameter int BAUD_DIV    = BAUD_DIV_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dado_serial,
  output logic [DATA_BITS-1:0] dados,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_parada,
  output logic                 ocupado,
  output logic [3:0]           db_estado
);

  estado_e state_q, state_d;

  logic rx_s, meio, fim, ultimo;
  logic zera_cnt, zera_dados, desloca, amostra_par, carrega;

  neurosync_rx_serial_fd #(
    .BAUD_DIV   (BAUD_DIV),
    .DATA_BITS  (DATA_BITS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fd (
    .clock        (clock),
    .reset        (reset),
    .dado_serial  (dado_serial),
    .zera_cnt     (zera_cnt),
    .zera_dados   (zera_dados),
    .desloca      (desloca),
    .amostra_par  (amostra_par),
    .carrega      (carrega),
    .rx_s         (rx_s),
    .meio         (meio),
    .fim          (fim),
    .ultimo       (ultimo),
    .dados        (dados),
    .erro_paridade(erro_paridade),
    .erro_parada  (erro_parada)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INICIAL;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:  if (!rx_s) state_d = PARTIDA;
      // A start bit that is high again at its midpoint was a glitch.
      PARTIDA:  if (meio) state_d = rx_s ? INICIAL : DADOS;
      DADOS:    if (fim && ultimo) state_d = PARIDADE;
      PARIDADE: if (fim) state_d = PARADA;
      PARADA:   if (fim) state_d = FIM;
      // A low stop bit may be a break; wait for idle before hunting starts.
      FIM:      state_d = erro_parada ? ESPERA : INICIAL;
      ESPERA:   if (rx_s) state_d = INICIAL;
      default:  state_d = INICIAL;
    endcase
  end

  // Datapath controls and status outputs.
  always_comb begin
    zera_cnt    = (state_d != state_q);
    zera_dados  = (state_q == PARTIDA) && meio && !rx_s;
    desloca     = (state_q == DADOS) && fim;
    amostra_par = (state_q == PARIDADE) && fim;
    carrega     = (state_q == PARADA) && fim;
    pronto      = (state_q == FIM);
    ocupado     = (state_q != INICIAL) && (state_q != FIM);
    db_estado   = state_q;
  end

endmodule

// File: tb/tb_neurosync_rx_serial.sv
// Directed bench for neurosync_rx_serial at BAUD_DIV=8.
module tb_neurosync_rx_serial;

  localparam int BD = 8;
  localparam int DB = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic          dado_serial;
  logic [DB-1:0] dados;
  logic          pronto, erro_paridade, erro_parada, ocupado;
  logic [3:0]    db_estado;

  neurosync_rx_serial #(.BAUD_DIV(BD), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .dado_serial  (dado_serial),
    .dados        (dados),
    .pronto       (pronto),
    .erro_paridade(erro_paridade),
    .erro_parada  (erro_parada),
    .ocupado      (ocupado),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Pronto monitor: counts high cycles and captures the reported frame.
  int            npr = 0;
  logic [DB-1:0] cap_d  [0:31];
  logic          cap_ep [0:31];
  logic          cap_es [0:31];
  always @(negedge clock) begin
    if (pronto) begin
      if (npr < 32) begin
        cap_d[npr]  = dados;
        cap_ep[npr] = erro_paridade;
        cap_es[npr] = erro_parada;
      end
      npr = npr + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    dado_serial = b;
    repeat (BD) @(negedge clock);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s);
    bit_out(1'b0);
    for (int i = 0; i < DB; i++) bit_out(d[i]);
    bit_out(p);
    bit_out(s);
    dado_serial = 1'b1;
  endtask

  typedef struct {
    logic [DB-1:0] d;
    logic          p;
    logic          s;
    logic [DB-1:0] e_d;
    logic          e_ep;
    logic          e_es;
  } vec_t;

  vec_t vt [6];

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    vt[0] = '{7'h00, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0};
    vt[1] = '{7'h00, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0};
    vt[2] = '{7'h07, 1'b0, 1'b1, 7'h07, 1'b0, 1'b0};
    vt[3] = '{7'h7F, 1'b0, 1'b1, 7'h7F, 1'b0, 1'b0};
    vt[4] = '{7'h35, 1'b0, 1'b1, 7'h35, 1'b1, 1'b0};
    vt[5] = '{7'h35, 1'b1, 1'b1, 7'h35, 1'b0, 1'b0};

    reset = 1'b0;
    dado_serial = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_dados", 32'(dados), 0);
    chk("rst_pronto", 32'(pronto), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_flags", {30'd0, erro_paridade, erro_parada}, 0);
    reset = 1'b1;
    repeat (BD * 2) @(negedge clock);
    chk("idle_estado", 32'(db_estado), 0);

    // Table of single frames.
    for (int i = 0; i < 6; i++) begin
      n0 = npr;
      send_frame(vt[i].d, vt[i].p, vt[i].s);
      repeat (BD * 2) @(negedge clock);
      chk($sformatf("v%0d_npronto", i), 32'(npr - n0), 1);
      chk($sformatf("v%0d_dados", i), 32'(cap_d[n0]), 32'(vt[i].e_d));
      chk($sformatf("v%0d_ep", i), 32'(cap_ep[n0]), 32'(vt[i].e_ep));
      chk($sformatf("v%0d_es", i), 32'(cap_es[n0]), 32'(vt[i].e_es));
      chk($sformatf("v%0d_held", i), 32'(dados), 32'(vt[i].e_d));
      chk($sformatf("v%0d_idle", i), {27'd0, ocupado, db_estado}, 0);
    end

    // Short low glitch while idle: start detected, then rejected.
    n0 = npr;
    dado_serial = 1'b0;
    repeat (2) @(negedge clock);
    dado_serial = 1'b1;
    @(negedge clock);
    chk("glitch_partida", 32'(db_estado), 1);
    chk("glitch_ocupado", 32'(ocupado), 1);
    repeat (BD * 3) @(negedge clock);
    chk("glitch_estado", 32'(db_estado), 0);
    chk("glitch_npronto", 32'(npr - n0), 0);
    chk("glitch_dados", 32'(dados), 32'h35);

    // Low stop bit followed by a held-low line (break).
    n0 = npr;
    bit_out(1'b0);
    for (int i = 0; i < DB; i++) bit_out(i == 0 || i == 6);
    bit_out(1'b1);
    dado_serial = 1'b0;
    repeat (BD * 20) @(negedge clock);
    chk("brk_npronto", 32'(npr - n0), 1);
    chk("brk_dados", 32'(cap_d[n0]), 32'h41);
    chk("brk_ep", 32'(cap_ep[n0]), 0);
    chk("brk_es", 32'(cap_es[n0]), 1);
    chk("brk_es_out", 32'(erro_parada), 1);
    chk("brk_espera", 32'(db_estado), 6);
    chk("brk_ocupado", 32'(ocupado), 1);
    dado_serial = 1'b1;
    repeat (6) @(negedge clock);
    chk("brk_release", 32'(db_estado), 0);
    repeat (BD * 2) @(negedge clock);
    chk("brk_npronto2", 32'(npr - n0), 1);

    // Back-to-back frames with no idle gap.
    n0 = npr;
    send_frame(7'h07, 1'b0, 1'b1);
    send_frame(7'h7F, 1'b0, 1'b1);
    repeat (BD * 2) @(negedge clock);
    chk("b2b_npronto", 32'(npr - n0), 2);
    chk("b2b_d0", 32'(cap_d[n0]), 32'h07);
    chk("b2b_d1", 32'(cap_d[n0 + 1]), 32'h7F);
    chk("b2b_err", {28'd0, cap_ep[n0], cap_es[n0], cap_ep[n0 + 1], cap_es[n0 + 1]}, 0);

    // Asynchronous reset during data bit 3 of a 0x35 frame.
    n0 = npr;
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    dado_serial = 1'b0;
    repeat (4) @(negedge clock);
    chk("mid_busy", 32'(ocupado), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_dados", 32'(dados), 0);
    chk("mid_ctrl", {28'd0, pronto, ocupado, erro_paridade, erro_parada}, 0);
    chk("mid_estado", 32'(db_estado), 0);
    @(negedge clock);
    dado_serial = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (BD * 10) @(negedge clock);
    chk("mid_npronto", 32'(npr - n0), 0);
    send_frame(7'h35, 1'b1, 1'b1);
    repeat (BD * 2) @(negedge clock);
    chk("post_npronto", 32'(npr - n0), 1);
    chk("post_dados", 32'(cap_d[n0]), 32'h35);
    chk("post_err", {30'd0, cap_ep[n0], cap_es[n0]}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
